config_loader: RTL
==================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter NUM_TILES, default 16, is the number of tiles driven (range 1..256).
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cfg_in_valid  input  1  upstream word valid.
REQ-005 cfg_in_data  input  32  upstream stream word.
REQ-006 cfg_in_ready  output  1  word accepted when valid and ready are both high.
REQ-007 config_data  output  32  data broadcast to the config_data input of every tile.
REQ-008 config_en  output  NUM_TILES  one-hot tile write strobe.
REQ-009 busy  output  1  high while a packet is in progress (state other than IDLE).
REQ-010 done  output  1  one-cycle pulse at packet completion.
REQ-011 err  output  1  sticky error flag.
REQ-012 err_clear  input  1  synchronous clear of err.

Function
REQ-013 States SHALL be IDLE, LOAD and CHECK (CHECK exists only with CONFIG_CHECKSUM_EN).
REQ-014 cfg_in_ready SHALL be 1 in every state when reset is low, and 0 while reset is high.
REQ-015 In IDLE, an accepted word is a header with the following fields:
- [31:16] sync, which must be 16'hC0F1.
- [15:8] count N.
- [7:0] start tile S.
REQ-016 Header with a bad sync: the word is dropped, err is set next cycle, and the state stays IDLE.
REQ-017 Valid header with N>0: the state goes to LOAD, the tile index is loaded with S (9-bit), and the remaining count is loaded with N.
REQ-018 Valid header with N=0: done pulses next cycle (without CONFIG_CHECKSUM_EN) and the state stays IDLE.
REQ-019 In LOAD, each accepted word W SHALL produce, on the next cycle, config_data=W and config_en=one-hot(index), provided index<NUM_TILES.
REQ-020 In LOAD, a word whose index>=NUM_TILES: config_en stays all-zero, err is set, and the word still counts toward N.
REQ-021 After each accepted payload word, the index increments by 1 and the remaining count decrements by 1.
REQ-022 The index SHALL NOT wrap: the 9-bit index holds S+N-1 at most 509.
REQ-023 After the last payload word (remaining count 1 -> 0), the state goes to IDLE, or to CHECK with CONFIG_CHECKSUM_EN.
REQ-024 After the last payload word without CONFIG_CHECKSUM_EN, done SHALL pulse in the same cycle as the final config_en.
REQ-025 config_en SHALL be all-zero in every cycle that does not follow an accepted payload word; at most one bit is ever high.
REQ-026 config_data SHALL hold its last value when config_en is zero.
REQ-027 Cycles with cfg_in_valid low SHALL stall the packet with no state change.
REQ-028 If err_clear and an error event occur in the same cycle, err SHALL be 1 (set wins).
REQ-029 Latency from word acceptance to config_en is exactly 1 cycle.

Reset
REQ-030 While reset is high, the block SHALL be held in reset with state=IDLE, config_data=0, config_en=0, busy=0, done=0, err=0, index=0, count=0, and checksum=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; no further config_en is issued for it.
REQ-032 After reset deasserts, the first accepted word is treated as a header.

Configuration
REQ-033 Macro CONFIG_CHECKSUM_EN SHALL compile in packet checksum support.
REQ-034 With CONFIG_CHECKSUM_EN defined, the following behaviour SHALL apply:
- A 32-bit XOR accumulator, cleared at each header, folds in every payload word.
- After the payload, the state goes to CHECK.
- The next accepted word is compared with the accumulator.
- On a mismatch, err is set.
- In either case, done pulses next cycle and the state returns to IDLE.
- With N=0, CHECK expects 32'h0.
REQ-035 Without CONFIG_CHECKSUM_EN, no CHECK state and no accumulator SHALL exist, and the packet ends after its payload.

Verification
REQ-036 Header 32'hC0F1_0302, then payload A,B,C -> config_en = 0x0004, 0x0008, 0x0010 on consecutive cycles carrying A, B, C; done pulses with 0x0010; err=0.
REQ-037 Header 32'hDEAD_0100 -> no config_en, err=1, busy=0; a following valid header is processed normally.
REQ-038 NUM_TILES=16, header 32'hC0F1_020F, two words -> config_en=0x8000 once, then a silent cycle, err=1, done pulses.
REQ-039 Payload with cfg_in_valid toggling 1-0-1 -> config_en appears only one cycle after each accepted word; index is unaffected by gaps.
REQ-040 Reset asserted after 1 of 3 payload words -> outputs zero immediately; the next word is parsed as a header.
REQ-041 With CONFIG_CHECKSUM_EN: payload 0x1, 0x2 and check word 0x3 -> err=0 and done; check word 0x4 -> err=1 and done.

Source files
------------

// File: rtl/config_loader.sv
// rtl/config_loader.sv - stream-to-tile configuration loader (optional checksum: CONFIG_CHECKSUM_EN)
module config_loader #(
    parameter int NUM_TILES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_in_valid,
    input  logic [31:0]          cfg_in_data,
    output logic                 cfg_in_ready,
    output logic [31:0]          config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 err_clear
);

`ifdef CONFIG_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

    localparam logic [15:0] SYNC = 16'hC0F1;

    state_t                 state, state_n;
    logic [8:0]             idx, idx_n;
    logic [7:0]             cnt, cnt_n;
    logic [31:0]            data_n;
    logic [NUM_TILES-1:0]   en_n;
    logic                   done_n;
    logic                   err_set;
    logic                   accept;
`ifdef CONFIG_CHECKSUM_EN
    logic [31:0]            sum, sum_n;
`endif

    // The loader never backpressures; it only refuses words while held in reset.
    assign cfg_in_ready = ~reset;
    assign accept       = cfg_in_valid & cfg_in_ready;
    assign busy         = (state != IDLE);

    // Next-state and registered-output decode for header, payload and check words.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        data_n  = config_data;
        en_n    = '0;
        done_n  = 1'b0;
        err_set = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
        sum_n   = sum;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cfg_in_data[31:16] != SYNC) begin
                        err_set = 1'b1;
                    end else begin
                        idx_n = {1'b0, cfg_in_data[7:0]};
                        cnt_n = cfg_in_data[15:8];
`ifdef CONFIG_CHECKSUM_EN
                        sum_n = 32'h0;
`endif
                        if (cfg_in_data[15:8] != 8'd0) begin
                            state_n = LOAD;
                        end else begin
`ifdef CONFIG_CHECKSUM_EN
                            state_n = CHECK;
`else
                            done_n  = 1'b1;
`endif
                        end
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    // Out-of-range tiles are skipped but still consume a payload slot.
                    if (idx < 9'(NUM_TILES)) begin
                        data_n = cfg_in_data;
                        for (int i = 0; i < NUM_TILES; i++) begin
                            en_n[i] = (idx == 9'(i));
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                    idx_n = idx + 9'd1;
                    cnt_n = cnt - 8'd1;
`ifdef CONFIG_CHECKSUM_EN
                    sum_n = sum ^ cfg_in_data;
`endif
                    if (cnt == 8'd1) begin
`ifdef CONFIG_CHECKSUM_EN
                        state_n = CHECK;
`else
                        state_n = IDLE;
                        done_n  = 1'b1;
`endif
                    end
                end
            end
`ifdef CONFIG_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (cfg_in_data != sum) begin
                        err_set = 1'b1;
                    end
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; a new error event takes priority over err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 9'd0;
            cnt         <= 8'd0;
            config_data <= 32'h0;
            config_en   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
            sum         <= 32'h0;
`endif
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            config_data <= data_n;
            config_en   <= en_n;
            done        <= done_n;
`ifdef CONFIG_CHECKSUM_EN
            sum         <= sum_n;
`endif
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clear) begin
                err <= 1'b0;
            end
        end
    end

endmodule
